aes_key_sched_mc: RTL and testbench
===================================

Name: aes_key_sched_mc

Overview:
- Parametrised multi-slot AES key-schedule engine. It expands AES-128, AES-192 or AES-256 keys into round keys, one word per cycle.
- Holds NUM_SLOTS independent expanded keys in an internal round-key memory.
- The cipher datapath reads round keys by (slot, round) through a registered read port, including while another slot is being expanded.
- Successor to key_exp_outer: adds slots, a load handshake, per-slot mode, and read error flagging.

Parameters:
- NUM_SLOTS, 4, number of independent key slots (1..16).
- SLOT_W, $clog2(NUM_SLOTS) (minimum 1), slot index width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- key_in  in  256  cipher key, left-aligned (AES-128 uses [255:128], AES-192 uses [255:64])
- key_mode  in  2  01=AES-128, 10=AES-192, 11=AES-256, 00=reserved
- key_slot  in  SLOT_W  destination slot
- key_valid  in  1  load request
- key_ready  out  1  engine idle, can accept a load
- busy  out  1  expansion in progress
- err  out  1  one-cycle pulse: reserved mode, or key_slot >= NUM_SLOTS
- slot_rdy  out  NUM_SLOTS  per-slot "expanded keys valid"
- rd_en  in  1  read request
- rd_slot  in  SLOT_W  read slot
- rd_round  in  4  round index 0..14
- rd_key  out  128  round key
- rd_valid  out  1  read response strobe
- rd_err  out  1  response invalid (slot not ready, or round > Nr of slot)

Behaviour:
- Reset values: key_ready=1, busy=0, err=0, slot_rdy=0, rd_key=0, rd_valid=0, rd_err=0, FSM=IDLE. Reset mid-expansion aborts it; all slots become invalid.
- Nk/Nr/W per mode: AES-128 4/10/44, AES-192 6/12/52, AES-256 8/14/60.
- FSM states: IDLE, EXPAND.
- IDLE: key_ready=1. A load is accepted on an edge where key_valid && key_ready.
  - Bad mode or bad slot: pulse err the next cycle, stay IDLE, leave memory untouched.
  - Otherwise: latch key, mode and slot; clear slot_rdy[slot] at the same edge; go to EXPAND.
- EXPAND: busy=1, key_ready=0. Word counter i runs 0..W-1, one word per cycle.
  - i<Nk: w[i] = key word i.
  - Otherwise: w[i] = w[i-Nk] ^ t.
    - i%Nk==0: t = SubWord(RotWord(w[i-1])) ^ Rcon.
    - Nk==8 and i%8==4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
  - Rcon starts at 01 and advances by xtime after each use.
  - Sliding window of the last 8 words; no full word array.
  - When i%4==3, write {w[i-3],w[i-2],w[i-1],w[i]} to mem[slot][i/4].
  - After the write of word W-1: set slot_rdy[slot], store the slot's mode, return to IDLE.
  - slot_rdy rises W cycles after the accepting edge. key_ready is high again the following cycle.
- key_valid while busy is ignored: held off by key_ready=0; no queuing.
- Read port:
  - rd_en sampled at edge T; rd_valid, rd_key and rd_err are valid for exactly one cycle after T.
  - When rd_err=1, rd_key=0.
  - Reads run concurrently with expansion. A read of the slot being expanded returns rd_err=1, since its slot_rdy is 0.
- Reloading a ready slot invalidates it from the accept edge.

Optional Feature:
- Macro: AES_KEY_INV_ORDER_EN.
- Defined: extra input rd_inv (1 bit). When rd_inv=1, the effective round is Nr - rd_round. The range check is applied to rd_round before inversion. Used by the decryption datapath.
- Undefined: no rd_inv port; rounds are addressed directly.

Decomposition:
- Package aes_pkg holds:
  - mode encodings
  - NK/NR/W lookup functions per mode
  - MAX_ROUNDS=14
  - the Rcon xtime function
- Sub-module aes_sbox: combinational byte S-box, instantiated 4x for SubWord.
- Round-key memory is an internal array of NUM_SLOTS*15 x 128 bits, with one write port and one registered read port.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c into slot 0 -> slot_rdy[0] rises 44 cycles after accept. Round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b into slot 1 -> ready after 52 cycles. Round 12 = e98ba06f448c773c8ecc720401002202. Round 13 read gives rd_err=1, rd_key=0.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 into slot 2 while reading slot 0 round 10 every cycle -> slot 0 reads stay correct throughout. Slot 2 round 14 = fe4890d1e6188d0b046df344706c631e.
- key_mode=00 -> err pulses one cycle, no slot_rdy change. key_valid held during EXPAND -> not accepted until key_ready returns.
- reset_n asserted mid-expansion of slot 3 with slots 0-2 ready -> slot_rdy=0 immediately. All reads return rd_err=1 after reset is released.
- AES_KEY_INV_ORDER_EN defined: AES-128 slot read with rd_inv=1, rd_round=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: mode encodings, per-mode Nk/Nr/W lookups
// and the GF(2^8) xtime used for Rcon and the S-box.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] MODE_RSVD = 2'b00;
  localparam logic [1:0] MODE_128  = 2'b01;
  localparam logic [1:0] MODE_192  = 2'b10;
  localparam logic [1:0] MODE_256  = 2'b11;

  localparam int MAX_ROUNDS = 14;

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_192: return 4'd12;
      MODE_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] w_of(input logic [1:0] mode);
    case (mode)
      MODE_192: return 6'd52;
      MODE_256: return 6'd60;
      default:  return 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) (as x^254)
// followed by the affine transform, so no 256-entry table is needed.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = prod of x^(2^k), k=1..7; zero maps to zero naturally
  always_comb begin
    sq  = data_i;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_mc.sv
// Multi-slot AES-128/192/256 key-schedule engine with registered round-key read port.
// Optional AES_KEY_INV_ORDER_EN adds rd_inv for reverse (decryption) round addressing.
//
// state    | meaning
// S_IDLE   | key_ready=1, waiting for a load request
// S_EXPAND | generating one schedule word per cycle into slot_q
module aes_key_sched_mc
  import aes_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [255:0]         key_in,
  input  logic [1:0]           key_mode,
  input  logic [SLOT_W-1:0]    key_slot,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 err,
  output logic [NUM_SLOTS-1:0] slot_rdy,
  input  logic                 rd_en,
  input  logic [SLOT_W-1:0]    rd_slot,
  input  logic [3:0]           rd_round,
`ifdef AES_KEY_INV_ORDER_EN
  input  logic                 rd_inv,
`endif
  output logic [127:0]         rd_key,
  output logic                 rd_valid,
  output logic                 rd_err
);

  localparam int RPS    = MAX_ROUNDS + 1;
  localparam int DEPTH  = NUM_SLOTS * RPS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [SLOT_W:0] SLOT_LIM = (SLOT_W + 1)'(NUM_SLOTS);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_EXPAND = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [255:0]               key_q, key_d;
  logic [1:0]                 mode_q, mode_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic [2:0]                 mod_q, mod_d;
  logic [7:0]                 rcon_q, rcon_d;
  logic [7:0][31:0]           win_q, win_d;
  logic [NUM_SLOTS-1:0]       slot_rdy_q, slot_rdy_d;
  logic [NUM_SLOTS-1:0][1:0]  slot_mode_q, slot_mode_d;
  logic                       err_q, err_d;
  logic [127:0]               rd_key_q, rd_key_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       rd_err_q, rd_err_d;

  logic [127:0]               mem_q [DEPTH];

  logic [3:0]                 nk;
  logic [3:0]                 nk_m1;
  logic [5:0]                 w_last;
  word_t                      w_prev;
  word_t                      w_back;
  word_t                      sub_in;
  word_t                      sub_out;
  word_t                      t_word;
  word_t                      w_new;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;

  logic                       rd_slot_ok;
  logic [3:0]                 rd_nr;
  logic                       rd_ok;
  logic [3:0]                 eff_round;
  logic [ADDR_W-1:0]          rd_addr;

  assign nk     = nk_of(mode_q);
  assign nk_m1  = nk - 4'd1;
  assign w_last = w_of(mode_q) - 6'd1;

  // win_q[0] is w[i-1], win_q[k] is w[i-1-k]
  assign w_prev = win_q[0];
  assign w_back = win_q[nk_m1[2:0]];
  assign sub_in = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (sub_in[8*g +: 8]),
      .data_o (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    t_word = w_prev;
    if (mod_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk == 4'd8 && mod_q == 3'd4) begin
      t_word = sub_out;
    end
    if ({2'b00, nk} > cnt_q) begin
      w_new = key_q[255:224];
    end else begin
      w_new = w_back ^ t_word;
    end
  end

  assign wr_en   = (state_q == S_EXPAND) && (cnt_q[1:0] == 2'b11);
  assign wr_addr = ADDR_W'(slot_q) * ADDR_W'(RPS) + ADDR_W'(cnt_q[5:2]);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {win_q[2], win_q[1], win_q[0], w_new};
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    mode_d      = mode_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    mod_d       = mod_q;
    rcon_d      = rcon_q;
    win_d       = win_q;
    slot_rdy_d  = slot_rdy_q;
    slot_mode_d = slot_mode_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (key_mode == MODE_RSVD || {1'b0, key_slot} >= SLOT_LIM) begin
            err_d = 1'b1;
          end else begin
            key_d                = key_in;
            mode_d               = key_mode;
            slot_d               = key_slot;
            cnt_d                = 6'd0;
            mod_d                = 3'd0;
            rcon_d               = 8'h01;
            slot_rdy_d[key_slot] = 1'b0;
            state_d              = S_EXPAND;
          end
        end
      end
      S_EXPAND: begin
        key_d = {key_q[223:0], 32'h00000000};
        win_d = {win_q[6:0], w_new};
        cnt_d = cnt_q + 6'd1;
        mod_d = ({1'b0, mod_q} == nk_m1) ? 3'd0 : mod_q + 3'd1;
        // Rcon is consumed only by derived words at i%Nk==0
        if ({2'b00, nk} <= cnt_q && mod_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (cnt_q == w_last) begin
          state_d             = S_IDLE;
          slot_rdy_d[slot_q]  = 1'b1;
          slot_mode_d[slot_q] = mode_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Range check uses the un-inverted round so rd_inv cannot wrap into a valid index
  always_comb begin
    rd_slot_ok = ({1'b0, rd_slot} < SLOT_LIM) && slot_rdy_q[rd_slot];
    rd_nr      = nr_of(slot_mode_q[rd_slot]);
    rd_ok      = rd_slot_ok && (rd_round <= rd_nr);
`ifdef AES_KEY_INV_ORDER_EN
    eff_round  = rd_inv ? (rd_nr - rd_round) : rd_round;
`else
    eff_round  = rd_round;
`endif
    rd_addr    = rd_ok ? (ADDR_W'(rd_slot) * ADDR_W'(RPS) + ADDR_W'(eff_round)) : '0;
    rd_valid_d = rd_en;
    rd_err_d   = rd_en && !rd_ok;
    rd_key_d   = (rd_en && rd_ok) ? mem_q[rd_addr] : 128'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      mode_q      <= MODE_RSVD;
      slot_q      <= '0;
      cnt_q       <= '0;
      mod_q       <= '0;
      rcon_q      <= 8'h01;
      win_q       <= '0;
      slot_rdy_q  <= '0;
      slot_mode_q <= '0;
      err_q       <= 1'b0;
      rd_key_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      mod_q       <= mod_d;
      rcon_q      <= rcon_d;
      win_q       <= win_d;
      slot_rdy_q  <= slot_rdy_d;
      slot_mode_q <= slot_mode_d;
      err_q       <= err_d;
      rd_key_q    <= rd_key_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign key_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_EXPAND);
  assign err       = err_q;
  assign slot_rdy  = slot_rdy_q;
  assign rd_key    = rd_key_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_aes_key_sched_mc.sv
// Bench for aes_key_sched_mc: FIPS-197 key-expansion vectors, concurrent reads,
// error paths and mid-expansion reset; read responses checked via a scoreboard queue.
module tb_aes_key_sched_mc;

  localparam int NS = 4;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic           clk;
  logic           reset_n;
  logic [255:0]   key_in;
  logic [1:0]     key_mode;
  logic [1:0]     key_slot;
  logic           key_valid;
  logic           key_ready;
  logic           busy;
  logic           err;
  logic [NS-1:0]  slot_rdy;
  logic           rd_en;
  logic [1:0]     rd_slot;
  logic [3:0]     rd_round;
  logic           rd_inv;
  logic [127:0]   rd_key;
  logic           rd_valid;
  logic           rd_err;

  typedef struct {
    logic         err;
    logic [127:0] key;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  aes_key_sched_mc #(.NUM_SLOTS(NS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_in    (key_in),
    .key_mode  (key_mode),
    .key_slot  (key_slot),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .err       (err),
    .slot_rdy  (slot_rdy),
    .rd_en     (rd_en),
    .rd_slot   (rd_slot),
    .rd_round  (rd_round),
`ifdef AES_KEY_INV_ORDER_EN
    .rd_inv    (rd_inv),
`endif
    .rd_key    (rd_key),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  // Read-response scoreboard
  always @(negedge clk) begin
    if (reset_n && rd_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 rd_err=%0b rd_key=%h, required no response", rd_err, rd_key);
      end else begin
        mon_e = sb_q.pop_front();
        if (rd_err !== mon_e.err || rd_key !== mon_e.key) begin
          n_fail++;
          $display("FAIL rd_rsp: got err=%0b key=%h, required err=%0b key=%h", rd_err, rd_key, mon_e.err, mon_e.key);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic e_err, input logic [127:0] e_key);
    rsp_t r;
    r.err = e_err;
    r.key = e_key;
    sb_q.push_back(r);
  endtask

  task automatic read_req(input logic [1:0] slot, input logic [3:0] round, input logic inv,
                          input logic e_err, input logic [127:0] e_key);
    rd_en    = 1'b1;
    rd_slot  = slot;
    rd_round = round;
    rd_inv   = inv;
    push_exp(e_err, e_key);
    tick();
    rd_en  = 1'b0;
    rd_inv = 1'b0;
  endtask

  task automatic start_load(input logic [255:0] k, input logic [1:0] m, input logic [1:0] s);
    key_in    = k;
    key_mode  = m;
    key_slot  = s;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_rdy(input int s, output int n);
    n = 0;
    while (!slot_rdy[s] && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({key_ready, busy, err, slot_rdy, rd_valid, rd_err} !== 9'b1_0_0_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 100000000", {key_ready, busy, err, slot_rdy, rd_valid, rd_err});
    end
    n_checks++;
    if (rd_key !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rd_key: got %h, required 0", rd_key);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_aes128();
    int n;
    start_load(K128, 2'b01, 2'd0);
    n_checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a128_busy: got busy=%0b key_ready=%0b, required 1/0", busy, key_ready);
    end
    wait_rdy(0, n);
    n_checks++;
    if (n != 44) begin
      n_fail++;
      $display("FAIL a128_latency: got %0d cycles, required 44", n);
    end
    tick();
    n_checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL a128_idle: got key_ready=%0b busy=%0b, required 1/0", key_ready, busy);
    end
    read_req(2'd0, 4'd0, 1'b0, 1'b0, R128_0);
    read_req(2'd0, 4'd1, 1'b0, 1'b0, R128_1);
    read_req(2'd0, 4'd10, 1'b0, 1'b0, R128_10);
    read_req(2'd0, 4'd11, 1'b0, 1'b1, 128'h0);
    tick();
  endtask

`ifdef AES_KEY_INV_ORDER_EN
  task automatic test_inv();
    read_req(2'd0, 4'd0, 1'b1, 1'b0, R128_10);
    read_req(2'd0, 4'd10, 1'b1, 1'b0, R128_0);
    read_req(2'd0, 4'd9, 1'b1, 1'b0, R128_1);
    read_req(2'd0, 4'd11, 1'b1, 1'b1, 128'h0);
    tick();
  endtask
`endif

  task automatic test_aes192();
    int n;
    start_load(K192, 2'b10, 2'd1);
    wait_rdy(1, n);
    n_checks++;
    if (n != 52) begin
      n_fail++;
      $display("FAIL a192_latency: got %0d cycles, required 52", n);
    end
    tick();
    read_req(2'd1, 4'd0, 1'b0, 1'b0, R192_0);
    read_req(2'd1, 4'd1, 1'b0, 1'b0, R192_1);
    read_req(2'd1, 4'd12, 1'b0, 1'b0, R192_12);
    read_req(2'd1, 4'd13, 1'b0, 1'b1, 128'h0);
    tick();
  endtask

  task automatic test_aes256_concurrent();
    int n;
    rd_en     = 1'b1;
    rd_slot   = 2'd0;
    rd_round  = 4'd10;
    key_in    = K256;
    key_mode  = 2'b11;
    key_slot  = 2'd2;
    key_valid = 1'b1;
    push_exp(1'b0, R128_10);
    tick();
    key_valid = 1'b0;
    n = 0;
    while (!slot_rdy[2] && n < 200) begin
      if (n == 20) begin
        rd_slot = 2'd2;
        push_exp(1'b1, 128'h0);
      end else begin
        rd_slot = 2'd0;
        push_exp(1'b0, R128_10);
      end
      tick();
      n++;
    end
    rd_en = 1'b0;
    n_checks++;
    if (n != 60) begin
      n_fail++;
      $display("FAIL a256_latency: got %0d cycles, required 60", n);
    end
    tick();
    read_req(2'd2, 4'd0, 1'b0, 1'b0, R256_0);
    read_req(2'd2, 4'd1, 1'b0, 1'b0, R256_1);
    read_req(2'd2, 4'd14, 1'b0, 1'b0, R256_14);
    read_req(2'd3, 4'd0, 1'b0, 1'b1, 128'h0);
    tick();
  endtask

  task automatic test_bad_mode();
    start_load(K128, 2'b00, 2'd3);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_mode_err: got err=%0b, required 1", err);
    end
    n_checks++;
    if (slot_rdy !== 4'b0111 || key_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_mode_state: got slot_rdy=%b key_ready=%0b busy=%0b, required 0111/1/0", slot_rdy, key_ready, busy);
    end
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_mode_pulse: got err=%0b, required 0", err);
    end
  endtask

  task automatic test_busy_hold();
    int n;
    key_in    = K128;
    key_mode  = 2'b01;
    key_slot  = 2'd3;
    key_valid = 1'b1;
    tick();
    // A different request held during expansion must not be taken
    key_in   = K256;
    key_mode = 2'b11;
    n = 0;
    while (!slot_rdy[3] && n < 200) begin
      if (n == 10) begin
        n_checks++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_busy: got key_ready=%0b busy=%0b, required 0/1", key_ready, busy);
        end
      end
      tick();
      n++;
    end
    key_valid = 1'b0;
    n_checks++;
    if (n != 44) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d cycles, required 44", n);
    end
    tick();
    n_checks++;
    if (slot_rdy !== 4'b1111 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_state: got slot_rdy=%b busy=%0b, required 1111/0", slot_rdy, busy);
    end
    read_req(2'd3, 4'd10, 1'b0, 1'b0, R128_10);
    read_req(2'd3, 4'd11, 1'b0, 1'b1, 128'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    start_load(K256, 2'b11, 2'd3);
    repeat (10) tick();
    n_checks++;
    if (busy !== 1'b1 || slot_rdy !== 4'b0111) begin
      n_fail++;
      $display("FAIL rmid_pre: got busy=%0b slot_rdy=%b, required 1/0111", busy, slot_rdy);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (slot_rdy !== 4'b0000 || busy !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_async: got slot_rdy=%b busy=%0b key_ready=%0b, required 0000/0/1", slot_rdy, busy, key_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int s = 0; s < NS; s++) begin
      read_req(2'(s), 4'd0, 1'b0, 1'b1, 128'h0);
    end
    repeat (70) tick();
    n_checks++;
    if (slot_rdy !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_after: got slot_rdy=%b busy=%0b, required 0000/0", slot_rdy, busy);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    key_in    = '0;
    key_mode  = 2'b00;
    key_slot  = 2'd0;
    key_valid = 1'b0;
    rd_en     = 1'b0;
    rd_slot   = 2'd0;
    rd_round  = 4'd0;
    rd_inv    = 1'b0;

    test_reset();
    test_aes128();
`ifdef AES_KEY_INV_ORDER_EN
    test_inv();
`endif
    test_aes192();
    test_aes256_concurrent();
    test_bad_mode();
    test_busy_hold();
    test_reset_mid();

    repeat (3) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d responses outstanding, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
